// File: rtl/tbot_timebase_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tbot_timebase_pkg
// Brief    : Shared defaults and config FSM encoding for the tick scheduler.
// Revision : 1.0
// ============================================================================
package tbot_timebase_pkg;

  localparam int PRESCALE_DEF = 50;
  localparam int DIV_W_DEF    = 24;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } cfg_state_e;

endpackage : tbot_timebase_pkg
`default_nettype wire

// File: rtl/tick_channel.sv
`default_nettype none
// ============================================================================
// Module   : tick_channel
// Brief    : One rate-divided channel: base-tick divider, tick pulse, square wave.
// Revision : 1.0
// ============================================================================
module tick_channel
  import tbot_timebase_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_base_tick,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_load_div,
  output logic             o_tick,
  output logic             o_clk_div
);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic             r_tick;
  logic             r_clk_div;
  logic             w_running;
  logic             w_term;

  assign w_running = i_en && (r_div != '0);
  assign w_term    = (r_cnt == (r_div - DIV_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div     <= '0;
      r_cnt     <= '0;
      r_tick    <= 1'b0;
      r_clk_div <= 1'b0;
    end else if (i_load) begin
      // A load restarts the period and beats a coincident terminal count.
      r_div     <= i_load_div;
      r_cnt     <= '0;
      r_tick    <= 1'b0;
      r_clk_div <= w_running ? r_clk_div : 1'b0;
    end else if (!w_running) begin
      r_cnt     <= '0;
      r_tick    <= 1'b0;
      r_clk_div <= 1'b0;
    end else if (i_base_tick && w_term) begin
      r_cnt     <= '0;
      r_tick    <= 1'b1;
      r_clk_div <= ~r_clk_div;
    end else if (i_base_tick) begin
      r_cnt     <= r_cnt + DIV_W'(1);
      r_tick    <= 1'b0;
    end else begin
      r_tick    <= 1'b0;
    end
  end

  assign o_tick    = r_tick;
  assign o_clk_div = r_clk_div;

endmodule : tick_channel
`default_nettype wire

// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tick_scheduler
// Brief    : Prescaled base tick feeding NUM_CH divider channels, with a
//            handshake config path that applies loads on base-tick boundaries.
// Revision : 1.0
// ============================================================================
module tick_scheduler
  import tbot_timebase_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 3,
  parameter int PRESCALE = PRESCALE_DEF,
  parameter int DIV_W    = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic [DIV_W-1:0]  i_cfg_div,
  output logic              o_cfg_err,
  input  logic [NUM_CH-1:0] i_ch_en,
  output logic              o_base_tick,
  output logic [NUM_CH-1:0] o_tick,
  output logic [NUM_CH-1:0] o_clk_div
);

  localparam int              PS_W      = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] c_PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]   r_presc;
  cfg_state_e        r_state;
  logic [CH_W-1:0]   r_pend_ch;
  logic [DIV_W-1:0]  r_pend_div;
  logic              r_cfg_err;
  logic              w_base_tick;
  logic              w_accept;
  logic              w_apply;
  logic              w_ch_bad;
  logic [NUM_CH-1:0] w_load;

  assign w_base_tick = (r_presc == c_PS_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_base_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PS_W'(1);
    end
  end

  assign w_accept = i_cfg_valid && (r_state == IDLE);
  assign w_apply  = (r_state == APPLY) && w_base_tick;
  assign w_ch_bad = (int'(r_pend_ch) >= NUM_CH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pend_ch  <= '0;
      r_pend_div <= '0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cfg_err <= w_apply && w_ch_bad;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_pend_ch  <= i_cfg_ch;
            r_pend_div <= i_cfg_div;
            r_state    <= APPLY;
          end
        end
        APPLY: begin
          if (w_base_tick) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // An out-of-range pending channel matches no index, so nothing loads.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_load[i] = w_apply && (r_pend_ch == CH_W'(i));

    tick_channel #(
      .DIV_W (DIV_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .i_base_tick (w_base_tick),
      .i_en        (i_ch_en[i]),
      .i_load      (w_load[i]),
      .i_load_div  (r_pend_div),
      .o_tick      (o_tick[i]),
      .o_clk_div   (o_clk_div[i])
    );
  end

  assign o_cfg_ready = (r_state == IDLE);
  assign o_cfg_err   = r_cfg_err;
  assign o_base_tick = w_base_tick;

endmodule : tick_scheduler
`default_nettype wire

// File: tb/tb_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_scheduler
// Brief    : Directed self-checking bench for tick_scheduler (PRESCALE = 4).
// Revision : 1.0
// ============================================================================
module tb_tick_scheduler;

  logic        clk;
  logic        rst;
  logic        i_cfg_valid;
  logic        o_cfg_ready;
  logic [2:0]  i_cfg_ch;
  logic [23:0] i_cfg_div;
  logic        o_cfg_err;
  logic [3:0]  i_ch_en;
  logic        o_base_tick;
  logic [3:0]  o_tick;
  logic [3:0]  o_clk_div;

  tick_scheduler #(
    .NUM_CH   (4),
    .CH_W     (3),
    .PRESCALE (4),
    .DIV_W    (24)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_cfg_valid (i_cfg_valid),
    .o_cfg_ready (o_cfg_ready),
    .i_cfg_ch    (i_cfg_ch),
    .i_cfg_div   (i_cfg_div),
    .o_cfg_err   (o_cfg_err),
    .i_ch_en     (i_ch_en),
    .o_base_tick (o_base_tick),
    .o_tick      (o_tick),
    .o_clk_div   (o_clk_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;
  int          err_cnt  = 0;
  int          err_cyc  = -1;
  int          w0       = 0;
  logic [63:0] ob_tick [4];
  logic [63:0] ob_div  [4];

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle c is the window after the c-th edge since reset release.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (o_cfg_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
  endtask

  task automatic window(input int n);
    w0 = cyc;
    for (int ch = 0; ch < 4; ch++) begin
      ob_tick[ch] = '0;
      ob_div[ch]  = '0;
    end
    for (int k = 0; k < n; k++) begin
      for (int ch = 0; ch < 4; ch++) begin
        ob_tick[ch][k] = o_tick[ch];
        ob_div[ch][k]  = o_clk_div[ch];
      end
      step();
    end
  endtask

  function automatic logic [63:0] exp_tick(input int f, input int p, input int n);
    logic [63:0] v = '0;
    for (int k = 0; k < n; k++) begin
      int c = w0 + k;
      if (f >= 0 && c >= f && ((c - f) % p) == 0) v[k] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic lvl(input int c, input int f, input int p, input logic l0);
    if (f < 0 || c < f) return l0;
    return l0 ^ ((((c - f) / p + 1) % 2) != 0);
  endfunction

  function automatic logic [63:0] exp_div(input int f, input int p, input int n, input logic l0);
    logic [63:0] v = '0;
    for (int k = 0; k < n; k++) v[k] = lvl(w0 + k, f, p, l0);
    return v;
  endfunction

  // Last APPLY cycle for an accept at cycle a: next cycle with prescaler == 3.
  function automatic int exp_last(input int a);
    return a + 1 + (3 - ((a + 1) % 4));
  endfunction

  task automatic cfg_send(input logic [2:0] ch, input logic [23:0] dv,
                          output int a, output int l);
    int n;
    i_cfg_valid = 1'b1;
    i_cfg_ch    = ch;
    i_cfg_div   = dv;
    n = 0;
    while (!o_cfg_ready && n < 64) begin
      step();
      n++;
    end
    if (n >= 64) chk_eq("cfg_accept_timeout", 64'd1, 64'd0);
    a = cyc;
    step();
    i_cfg_valid = 1'b0;
    n = 0;
    while (!o_cfg_ready && n < 64) begin
      step();
      n++;
    end
    if (n >= 64) chk_eq("cfg_apply_timeout", 64'd1, 64'd0);
    l = cyc - 1;
  endtask

  initial begin
    int a, l, l2, l3, a1, l1, a2, lb, n, r, e1, f2r;
    logic [63:0] bt;
    logic l0;

    rst         = 1'b1;
    i_cfg_valid = 1'b0;
    i_cfg_ch    = '0;
    i_cfg_div   = '0;
    i_ch_en     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_tick",      64'(o_tick),      64'd0);
    chk_eq("rst_clk_div",   64'(o_clk_div),   64'd0);
    chk_eq("rst_cfg_ready", 64'(o_cfg_ready), 64'd1);
    chk_eq("rst_cfg_err",   64'(o_cfg_err),   64'd0);
    chk_eq("rst_base_tick", 64'(o_base_tick), 64'd0);
    rst = 1'b0;
    cyc = 0;

    // Base tick on cycles 3, 7, 11 after release.
    bt = '0;
    for (int k = 0; k < 12; k++) begin
      bt[k] = o_base_tick;
      step();
    end
    chk_eq("base_tick_pattern", bt, 64'h888);

    // Channel 0, div 3.
    i_ch_en = 4'b0001;
    cfg_send(3'd0, 24'd3, a, l2);
    chk_eq("t2_load_cycle", 64'(l2), 64'(exp_last(a)));
    window(34);
    chk_eq("t2_tick0",   ob_tick[0], exp_tick(l2 + 13, 12, 34));
    chk_eq("t2_div0",    ob_div[0],  exp_div(l2 + 13, 12, 34, 1'b0));
    chk_eq("t2_others",  ob_tick[1] | ob_tick[2] | ob_tick[3] | ob_div[1] | ob_div[2] | ob_div[3], 64'd0);

    // Reconfigure ch0 to div 1, landing on its own terminal-count edge.
    cfg_send(3'd0, 24'd1, a, l3);
    chk_eq("t3_load_cycle", 64'(l3), 64'(exp_last(a)));
    chk_eq("t3_on_term",    64'((l3 - l2) % 12), 64'd0);
    l0 = lvl(l3, l2 + 13, 12, 1'b0);
    window(24);
    chk_eq("t3_no_tick_on_load", 64'(ob_tick[0][0]), 64'd0);
    chk_eq("t3_tick0", ob_tick[0], exp_tick(l3 + 5, 4, 24));
    chk_eq("t3_div0",  ob_div[0],  exp_div(l3 + 5, 4, 24, l0));

    // Back-to-back requests with valid held high.
    i_ch_en     = 4'b0111;
    i_cfg_valid = 1'b1;
    i_cfg_ch    = 3'd1;
    i_cfg_div   = 24'd2;
    a1 = cyc;
    step();
    i_cfg_ch  = 3'd2;
    i_cfg_div = 24'd5;
    n = 0;
    while (!o_cfg_ready && n < 64) begin
      step();
      n++;
    end
    l1 = cyc - 1;
    a2 = cyc;
    step();
    i_cfg_valid = 1'b0;
    n = 0;
    while (!o_cfg_ready && n < 64) begin
      step();
      n++;
    end
    lb = cyc - 1;
    chk_eq("t4_first_load",   64'(l1), 64'(exp_last(a1)));
    chk_eq("t4_second_accept", 64'(a2), 64'(l1 + 1));
    chk_eq("t4_second_load",  64'(lb), 64'(exp_last(a2)));
    window(44);
    chk_eq("t4_tick1", ob_tick[1], exp_tick(l1 + 9, 8, 44));
    chk_eq("t4_div1",  ob_div[1],  exp_div(l1 + 9, 8, 44, 1'b0));
    chk_eq("t4_tick2", ob_tick[2], exp_tick(lb + 21, 20, 44));
    chk_eq("t4_tick0", ob_tick[0], exp_tick(l3 + 5, 4, 44));

    // Out-of-range channel.
    chk_eq("t5_no_prior_err", 64'(err_cnt), 64'd0);
    err_cnt = 0;
    cfg_send(3'd5, 24'd7, a, l);
    chk_eq("t5_err_count", 64'(err_cnt), 64'd1);
    chk_eq("t5_err_cycle", 64'(err_cyc), 64'(l + 1));
    window(40);
    chk_eq("t5_err_single", 64'(err_cnt), 64'd1);
    chk_eq("t5_tick0", ob_tick[0], exp_tick(l3 + 5, 4, 40));
    chk_eq("t5_tick1", ob_tick[1], exp_tick(l1 + 9, 8, 40));
    chk_eq("t5_tick2", ob_tick[2], exp_tick(lb + 21, 20, 40));
    chk_eq("t5_ch3",   ob_tick[3] | ob_div[3], 64'd0);

    // Drop enable while clk_div[2] is high, then re-enable.
    n = 0;
    while (!o_clk_div[2] && n < 100) begin
      step();
      n++;
    end
    chk_eq("t6_div2_high_seen", 64'(o_clk_div[2]), 64'd1);
    i_ch_en = 4'b0011;
    step();
    chk_eq("t6_disable_div2",  64'(o_clk_div[2]), 64'd0);
    chk_eq("t6_disable_tick2", 64'(o_tick[2]),    64'd0);
    r       = cyc;
    i_ch_en = 4'b0111;
    e1      = r + (3 - (r % 4));
    f2r     = e1 + 16 + 1;
    window(44);
    chk_eq("t6_reen_tick2", ob_tick[2], exp_tick(f2r, 20, 44));
    chk_eq("t6_reen_div2",  ob_div[2],  exp_div(f2r, 20, 44, 1'b0));

    // Reset in the middle of APPLY.
    n = 0;
    while ((cyc % 4) != 0 && n < 8) begin
      step();
      n++;
    end
    i_ch_en     = 4'b1111;
    i_cfg_valid = 1'b1;
    i_cfg_ch    = 3'd3;
    i_cfg_div   = 24'd1;
    step();
    i_cfg_valid = 1'b0;
    chk_eq("t6_in_apply", 64'(o_cfg_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk_eq("t6_arst_ready",   64'(o_cfg_ready), 64'd1);
    chk_eq("t6_arst_tick",    64'(o_tick),      64'd0);
    chk_eq("t6_arst_clk_div", 64'(o_clk_div),   64'd0);
    step();
    step();
    rst = 1'b0;
    cyc = 0;
    window(20);
    chk_eq("t6_post_rst_ticks", ob_tick[0] | ob_tick[1] | ob_tick[2] | ob_tick[3], 64'd0);
    chk_eq("t6_post_rst_divs",  ob_div[0] | ob_div[1] | ob_div[2] | ob_div[3], 64'd0);
    chk_eq("t6_post_rst_ready", 64'(o_cfg_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_tick_scheduler
`default_nettype wire
